// File: rtl/fifo_axis_pkg.sv
// Shared constants for the FIFO-to-AXI4-Stream reader.
//   DATA_W_DEF : default data width of the FIFO read port and the stream
//   BUF_DEPTH  : output skid-buffer entries (the credit logic assumes 2)
//   OCC_W      : width of the skid-buffer occupancy count
//   BEAT_CNT_W : width of the free-running handshaken-beat counter
//   PKT_CNT_W  : width of the beat-within-packet counter (BURST_LEN <= 65535)
package fifo_axis_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int BUF_DEPTH  = 2;
    localparam int OCC_W      = 2;
    localparam int BEAT_CNT_W = 32;
    localparam int PKT_CNT_W  = 16;

    // Read credit: (occ + inflight - pop) < BUF_DEPTH, rearranged as
    // occ + inflight < BUF_DEPTH + pop so the arithmetic never goes negative.
    function automatic logic read_credit(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        return ({1'b0, occ} + {2'b00, inflight}) < (3'(BUF_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fifo_axis_reader_if.sv
// AXI4-Stream beat channel used by the FIFO reader.
//   tvalid/tdata/tlast : driven by the master (the reader)
//   tready             : driven by the slave (downstream consumer)
interface fifo_axis_reader_if
    import fifo_axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/fifo_axis_skid.sv
// Two-entry in-order skid buffer between the FIFO read data and the stream.
//   clock, rst : clock and synchronous active-high reset
//   push, din  : write din behind the existing entries
//   pop        : drop the head entry (caller guarantees occ != 0)
//   dout       : head (oldest) entry
//   occ        : number of valid entries, 0..2
// A simultaneous push and pop leaves occ unchanged; the new word lands
// behind whatever entry remains after the pop.
module fifo_axis_skid
    import fifo_axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [OCC_W-1:0]  occ
);

    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic [OCC_W-1:0] wr_idx;

    // The write slot is computed after the pop has shifted the entries down.
    assign wr_idx = pop ? (occ_reg - 2'd1) : occ_reg;

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] shift_in;

            if (gi < BUF_DEPTH - 1) begin : g_shift
                assign shift_in = g_entry[gi+1].data_reg;
            end else begin : g_tail
                assign shift_in = data_reg;
            end

            always_ff @(posedge clock) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (push && (wr_idx == OCC_W'(gi))) begin
                    data_reg <= din;
                end else if (pop) begin
                    data_reg <= shift_in;
                end
            end
        end
    endgenerate

    assign dout = g_entry[0].data_reg;
    assign occ  = occ_reg;

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a first-word-fall-through-less FIFO read port (data one cycle after
// the read strobe) onto an AXI4-Stream master, framing BURST_LEN-beat packets.
//   clock, rst  : clock and synchronous active-high reset
//   fifo_empty  : registered FIFO empty flag
//   fifo_rd     : FIFO pop strobe (combinational from tready via the pop term)
//   fifo_dout   : FIFO read data, valid the cycle after fifo_rd
//   m_axis      : stream master (tvalid, tready, tdata, tlast)
//   beat_cnt    : handshaken beats since reset, wrapping at 2^32
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_W-1:0]     fifo_dout,
    fifo_axis_reader_if.master    m_axis,
    output logic [BEAT_CNT_W-1:0] beat_cnt
);

    generate
        if (BUF_DEPTH != fifo_axis_pkg::BUF_DEPTH || BURST_LEN < 1 || BURST_LEN > 65535) begin : g_param_check
            $error("fifo_axis_reader: BUF_DEPTH must be 2 and BURST_LEN 1..65535");
        end
    endgenerate

    localparam logic [PKT_CNT_W-1:0] LAST_IDX = PKT_CNT_W'(BURST_LEN - 1);

    logic                  rd_en_reg;     // low for one cycle after reset
    logic                  inflight_reg;  // read issued last cycle, data on fifo_dout now
    logic [PKT_CNT_W-1:0]  pkt_cnt_reg;
    logic [BEAT_CNT_W-1:0] beat_cnt_reg;
    logic [OCC_W-1:0]      occ;
    logic [DATA_W-1:0]     head;
    logic                  pop;

    fifo_axis_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clock (clock),
        .rst   (rst),
        .push  (inflight_reg),
        .pop   (pop),
        .din   (fifo_dout),
        .dout  (head),
        .occ   (occ)
    );

    assign m_axis.tvalid = (occ != '0);
    assign m_axis.tdata  = head;
    assign m_axis.tlast  = (pkt_cnt_reg == LAST_IDX) & m_axis.tvalid;
    assign pop           = m_axis.tvalid & m_axis.tready;

    // Counting the beat leaving this cycle lets reads continue back to back
    // while the buffer sits at one entry plus one in flight.
    assign fifo_rd  = rd_en_reg & ~fifo_empty & read_credit(occ, inflight_reg, pop);
    assign beat_cnt = beat_cnt_reg;

    always_ff @(posedge clock) begin
        if (rst) begin
            rd_en_reg    <= 1'b0;
            inflight_reg <= 1'b0;
            pkt_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
        end else begin
            rd_en_reg    <= 1'b1;
            inflight_reg <= fifo_rd;
            if (pop) begin
                pkt_cnt_reg  <= (pkt_cnt_reg == LAST_IDX) ? '0 : pkt_cnt_reg + 1'b1;
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
module tb_fifo_axis_reader;

    localparam int DW = 32;
    localparam int BL = 4;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic [DW-1:0] fifo_dout = '0;
    logic [31:0]   beat_cnt;

    fifo_axis_reader_if #(.DATA_W(DW)) axis ();

    fifo_axis_reader #(
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .BUF_DEPTH (2)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .m_axis     (axis),
        .beat_cnt   (beat_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] fq[$];        // FIFO contents model
    logic [DW-1:0] sb[$];        // expected beats, in order
    int            rd_total = 0;
    int            beat_total = 0;
    int            beat_idx = 0;
    int            cyc = 0;
    int            beat_cyc[$];

    // FIFO model: pop on fifo_rd, data one cycle later, registered empty flag.
    initial begin
        forever begin
            @(posedge clock);
            if (fifo_rd) begin
                rd_total <= rd_total + 1;
                if (fq.size() > 0) fifo_dout <= fq.pop_front();
                else               fifo_dout <= 32'hDEADBEEF;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Monitor: sampled on the falling edge; a beat seen here is taken at the next rising edge.
    initial begin
        int            lost;
        logic [DW-1:0] exp_w;
        logic          stall_prev;
        logic [DW-1:0] stall_data;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (fifo_rd) check_val("rd_while_empty", fifo_empty, 0);
            if (rst) begin
                // Everything read but not delivered (including a read in this cycle) is discarded.
                lost = rd_total + int'(fifo_rd) - beat_total;
                repeat (lost) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                end
                beat_total = rd_total + int'(fifo_rd);
                beat_idx   = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_val("hold_valid", axis.tvalid, 1);
                    check_val("hold_data", axis.tdata, stall_data);
                end
                if (axis.tvalid && axis.tready) begin
                    if (sb.size() == 0) begin
                        check_val("beat_with_empty_sb", sb.size(), 1);
                    end else begin
                        exp_w = sb.pop_front();
                        check_val("tdata", axis.tdata, exp_w);
                        check_val("tlast", axis.tlast, ((beat_idx % BL) == BL - 1) ? 1 : 0);
                    end
                    $display("beat %0d: tdata=0x%0h tlast=%0d cycle=%0d", beat_idx, axis.tdata, axis.tlast, cyc);
                    beat_idx++;
                    beat_total++;
                    beat_cyc.push_back(cyc);
                end
                stall_prev = axis.tvalid && !axis.tready;
                stall_data = axis.tdata;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + DW'(i));
            sb.push_back(base + DW'(i));
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (sb.size() != 0 && b > 0) begin
            tick(1);
            b--;
        end
        check_val("drain_done", sb.size(), 0);
        tick(2);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_fifo_rd"}, fifo_rd, 0);
        check_val({tag, "_tvalid"}, axis.tvalid, 0);
        check_val({tag, "_tlast"}, axis.tlast, 0);
        check_val({tag, "_tdata"}, axis.tdata, 0);
        check_val({tag, "_beat_cnt"}, beat_cnt, 0);
    endtask

    initial begin
        int r0;
        int b0;
        int budget;
        axis.tready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(2);
        check_idle_outputs("reset");

        // Preload 4 words, release reset, stream with tready=1
        load(4, 32'h1);
        tick(1);
        rst = 1'b0;
        check_val("rd_first_cycle_after_reset", fifo_rd, 0);
        axis.tready = 1'b1;
        beat_cyc.delete();
        tick(1);
        check_val("first_rd", fifo_rd, 1);
        check_val("tvalid_lat0", axis.tvalid, 0);
        tick(1);
        check_val("tvalid_lat1", axis.tvalid, 0);
        tick(1);
        check_val("tvalid_lat2", axis.tvalid, 1);
        check_val("first_tdata", axis.tdata, 32'h1);
        drain(50);
        check_val("t1_beat_cnt", beat_cnt, 4);
        check_val("t1_beats", beat_cyc.size(), 4);
        check_val("t1_span", beat_cyc[3] - beat_cyc[0], 3);

        // Backpressure: 8 words, tready low 10 cycles
        axis.tready = 1'b0;
        r0 = rd_total;
        load(8, 32'h100);
        tick(10);
        check_val("stall_rd_pulses", rd_total - r0, 2);
        check_val("stall_tvalid", axis.tvalid, 1);
        check_val("stall_tdata", axis.tdata, 32'h100);
        beat_cyc.delete();
        axis.tready = 1'b1;
        drain(60);
        check_val("t2_beats", beat_cyc.size(), 8);
        check_val("t2_span", beat_cyc[7] - beat_cyc[0], 7);

        // Packet framing: 10 more beats, counter ends at 2
        load(10, 32'h200);
        drain(60);
        check_val("pkt_cnt_after_10", dut.pkt_cnt_reg, 2);
        check_val("t3_beat_cnt", beat_cnt, 22);

        // tready toggling 1,0,1,0 over 6 words
        b0 = beat_total;
        load(6, 32'h300);
        axis.tready = 1'b0;
        budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            axis.tready = ~axis.tready;
            tick(1);
            budget--;
        end
        check_val("toggle_done", sb.size(), 0);
        axis.tready = 1'b0;
        tick(2);
        check_val("toggle_beats", beat_total - b0, 6);

        // Reset with a full buffer and a read issued in the reset cycle
        load(6, 32'h400);
        tick(6);
        check_val("pre_rst_tvalid", axis.tvalid, 1);
        rst = 1'b1;
        axis.tready = 1'b1;
        tick(1);
        check_idle_outputs("midrst");
        rst = 1'b0;
        check_val("midrst_rd_gap", fifo_rd, 0);
        drain(60);
        check_val("post_rst_beat_cnt", beat_cnt, 3);

        // beat_cnt wrap
        axis.tready = 1'b0;
        load(2, 32'h500);
        tick(4);
        check_val("wrap_tvalid", axis.tvalid, 1);
        dut.beat_cnt_reg = 32'hFFFF_FFFF;
        axis.tready = 1'b1;
        tick(1);
        axis.tready = 1'b0;
        check_val("beat_cnt_wrap", beat_cnt, 0);
        axis.tready = 1'b1;
        drain(40);
        check_val("beat_cnt_after_wrap", beat_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
